// File: rtl/nx_stream_packer.sv
// Packs 31-bit ctrl/mesh messages into 64-bit AXI4-stream beats, two lanes per beat.
// Half-filled beats are flushed alone after FLUSH_CYCLES idle cycles.
module nx_stream_packer #(
   parameter int AXI4_DATA_WIDTH = 64,
   parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH/8,
   parameter int AXI4_ID_WIDTH   = 1,
   parameter int FLUSH_CYCLES    = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [30:0]                ctrl_data_i,
   input  logic                       ctrl_valid_i,
   output logic                       ctrl_ready_o,
   input  logic [30:0]                mesh_data_i,
   input  logic                       mesh_valid_i,
   output logic                       mesh_ready_o,
   output logic [AXI4_DATA_WIDTH-1:0] stream_tdata,
   output logic [AXI4_STRB_WIDTH-1:0] stream_tkeep,
   output logic [AXI4_STRB_WIDTH-1:0] stream_tstrb,
   output logic [AXI4_ID_WIDTH-1:0]   stream_tid,
   output logic                       stream_tlast,
   output logic                       stream_tvalid,
   input  logic                       stream_tready,
   output logic                       idle_o
);

   localparam logic [7:0] TERM = 8'(FLUSH_CYCLES - 1);
   localparam logic [AXI4_STRB_WIDTH-1:0] STRB_FULL = '1;
   localparam logic [AXI4_STRB_WIDTH-1:0] STRB_HALF =
      AXI4_STRB_WIDTH'((1 << (AXI4_STRB_WIDTH/2)) - 1);

   logic [31:0]                low_q;
   logic                       low_vld_q;
   logic [7:0]                 cnt_q;
   logic                       prio_mesh_q;
   logic [63:0]                data_q;
   logic [AXI4_STRB_WIDTH-1:0] strb_q;
   logic                       vld_q;

   logic        out_free;
   logic        contend;
   logic        pick_ctrl;
   logic        pick_mesh;
   logic        room;
   logic        take;
   logic        at_term;
   logic        load_full;
   logic        load_half;
   logic [31:0] lane;

   always_comb begin
      out_free     = !vld_q || stream_tready;
      contend      = ctrl_valid_i && mesh_valid_i;
      pick_ctrl    = ctrl_valid_i && (!mesh_valid_i || !prio_mesh_q);
      pick_mesh    = mesh_valid_i && (!ctrl_valid_i || prio_mesh_q);
      // A full low lane can only be merged when the output slot frees up
      room         = !rst_i && (!low_vld_q || out_free);
      ctrl_ready_o = pick_ctrl && room;
      mesh_ready_o = pick_mesh && room;
      take         = ctrl_ready_o || mesh_ready_o;
      lane         = ctrl_ready_o ? {1'b1, ctrl_data_i}
                                  : {1'b0, mesh_data_i};
      at_term      = (cnt_q == TERM);
      load_full    = take && low_vld_q;
      load_half    = !take && low_vld_q && at_term && out_free;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         low_q       <= '0;
         low_vld_q   <= 1'b0;
         cnt_q       <= '0;
         prio_mesh_q <= 1'b0;
      end else begin
         if (take && contend)
            prio_mesh_q <= !prio_mesh_q;
         if (take) begin
            cnt_q <= '0;
            if (!low_vld_q) begin
               low_q     <= lane;
               low_vld_q <= 1'b1;
            end else begin
               low_vld_q <= 1'b0;
            end
         end else if (low_vld_q) begin
            if (load_half) begin
               low_vld_q <= 1'b0;
               cnt_q     <= '0;
            end else if (!at_term) begin
               cnt_q <= cnt_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
         strb_q <= '0;
         vld_q  <= 1'b0;
      end else if (load_full) begin
         data_q <= {lane, low_q};
         strb_q <= STRB_FULL;
         vld_q  <= 1'b1;
      end else if (load_half) begin
         data_q <= {32'h0, low_q};
         strb_q <= STRB_HALF;
         vld_q  <= 1'b1;
      end else if (stream_tready) begin
         vld_q  <= 1'b0;
      end
   end

   assign stream_tdata  = AXI4_DATA_WIDTH'(data_q);
   assign stream_tstrb  = strb_q;
   assign stream_tkeep  = strb_q;
   assign stream_tid    = '0;
   assign stream_tlast  = 1'b1;
   assign stream_tvalid = vld_q;
   assign idle_o        = !low_vld_q && !vld_q;

endmodule

// File: tb/tb_nx_stream_packer.sv
// Bench for nx_stream_packer: directed steps plus random traffic
// against a cycle model and an in-order lane scoreboard.
module tb_nx_stream_packer;

   localparam int FC = 16;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [30:0] ctrl_data_i;
   logic        ctrl_valid_i;
   logic        ctrl_ready_o;
   logic [30:0] mesh_data_i;
   logic        mesh_valid_i;
   logic        mesh_ready_o;
   logic [63:0] stream_tdata;
   logic [7:0]  stream_tkeep;
   logic [7:0]  stream_tstrb;
   logic [0:0]  stream_tid;
   logic        stream_tlast;
   logic        stream_tvalid;
   logic        stream_tready;
   logic        idle_o;

   nx_stream_packer dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .ctrl_data_i   (ctrl_data_i),
      .ctrl_valid_i  (ctrl_valid_i),
      .ctrl_ready_o  (ctrl_ready_o),
      .mesh_data_i   (mesh_data_i),
      .mesh_valid_i  (mesh_valid_i),
      .mesh_ready_o  (mesh_ready_o),
      .stream_tdata  (stream_tdata),
      .stream_tkeep  (stream_tkeep),
      .stream_tstrb  (stream_tstrb),
      .stream_tid    (stream_tid),
      .stream_tlast  (stream_tlast),
      .stream_tvalid (stream_tvalid),
      .stream_tready (stream_tready),
      .idle_o        (idle_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   bit [31:0] m_low;
   bit        m_lowv;
   bit [63:0] m_od;
   bit [7:0]  m_os;
   bit        m_ov;
   int        m_cnt;
   bit        m_prio_mesh;
   logic [31:0] sbq[$];
   bit        cr_s;
   bit        mr_s;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_low = 0; m_lowv = 0; m_od = 0; m_os = 0;
      m_ov = 0; m_cnt = 0; m_prio_mesh = 0;
      sbq.delete();
   endtask

   // One clock: check DUT against model, then advance the model.
   task automatic cyc();
      bit of, rdy, both;
      int win, n;
      logic [31:0] ln, a, b;
      #1;
      rdy  = stream_tready;
      of   = !m_ov || rdy;
      both = ctrl_valid_i && mesh_valid_i;
      if (both) win = m_prio_mesh ? 2 : 1;
      else if (ctrl_valid_i) win = 1;
      else if (mesh_valid_i) win = 2;
      else win = 0;
      if (rst_i || !(!m_lowv || of)) win = 0;
      ln = (win == 1) ? {1'b1, ctrl_data_i} : {1'b0, mesh_data_i};
      chk("ctrl_ready", ctrl_ready_o, win == 1);
      chk("mesh_ready", mesh_ready_o, win == 2);
      chk("tvalid", stream_tvalid, m_ov);
      chk("idle", idle_o, !m_lowv && !m_ov);
      chk("tlast", stream_tlast, 1);
      chk("tid", stream_tid, 0);
      if (m_ov) begin
         chk("tdata", stream_tdata, m_od);
         chk("tstrb", stream_tstrb, m_os);
         chk("tkeep", stream_tkeep, m_os);
      end
      if (!rst_i && stream_tvalid === 1'b1 && rdy) begin
         n = (stream_tstrb === 8'hFF) ? 2 : 1;
         if (sbq.size() < n) begin
            chk("sb_underflow", sbq.size(), n);
         end else begin
            a = sbq.pop_front();
            chk("sb_lo", stream_tdata[31:0], a);
            if (n == 2) begin
               b = sbq.pop_front();
               chk("sb_hi", stream_tdata[63:32], b);
            end else begin
               chk("sb_hi0", stream_tdata[63:32], 0);
            end
         end
      end
      if (ctrl_valid_i && ctrl_ready_o === 1'b1)
         sbq.push_back({1'b1, ctrl_data_i});
      if (mesh_valid_i && mesh_ready_o === 1'b1)
         sbq.push_back({1'b0, mesh_data_i});
      cr_s = ctrl_ready_o;
      mr_s = mesh_ready_o;
      @(posedge clk_i);
      if (rst_i) begin
         m_reset();
      end else begin
         if (m_ov && rdy) m_ov = 0;
         if (win != 0) begin
            if (both) m_prio_mesh = !m_prio_mesh;
            m_cnt = 0;
            if (!m_lowv) begin
               m_low = ln; m_lowv = 1;
            end else begin
               m_od = {ln, m_low}; m_os = 8'hFF;
               m_ov = 1; m_lowv = 0;
            end
         end else if (m_lowv) begin
            if (m_cnt == FC - 1) begin
               if (of) begin
                  m_od = {32'h0, m_low}; m_os = 8'h0F;
                  m_ov = 1; m_lowv = 0; m_cnt = 0;
               end
            end else begin
               m_cnt++;
            end
         end
      end
      #1;
   endtask

   initial begin
      int early, seen;
      logic [30:0] cd, md;
      rst_i = 1; stream_tready = 1;
      ctrl_valid_i = 1; mesh_valid_i = 1;
      ctrl_data_i = 0; mesh_data_i = 0;
      m_reset();
      @(posedge clk_i); #1;
      cyc();
      chk("rst_tvalid", stream_tvalid, 0);
      chk("rst_tdata", stream_tdata, 0);
      chk("rst_tstrb", stream_tstrb, 0);
      chk("rst_idle", idle_o, 1);
      chk("rst_ctrl_ready", ctrl_ready_o, 0);
      chk("rst_mesh_ready", mesh_ready_o, 0);
      rst_i = 0; ctrl_valid_i = 0; mesh_valid_i = 0;

      // two ctrl messages back to back
      ctrl_valid_i = 1; ctrl_data_i = 31'h1;
      cyc();
      chk("t1_acc0", cr_s, 1);
      chk("t1_nov", stream_tvalid, 0);
      ctrl_data_i = 31'h2;
      cyc();
      chk("t1_tvalid", stream_tvalid, 1);
      chk("t1_tdata", stream_tdata, 64'h80000002_80000001);
      chk("t1_tstrb", stream_tstrb, 8'hFF);
      chk("t1_tkeep", stream_tkeep, 8'hFF);
      chk("t1_tlast", stream_tlast, 1);
      ctrl_valid_i = 0;
      cyc();
      chk("t1_idle", idle_o, 1);

      // lone mesh message flushed after FC idle cycles
      mesh_valid_i = 1; mesh_data_i = 31'h7FFFFFFF;
      cyc();
      mesh_valid_i = 0;
      early = 0;
      for (int i = 1; i <= FC; i++) begin
         cyc();
         if (i < FC && stream_tvalid === 1'b1) early++;
      end
      chk("t2_early", early, 0);
      chk("t2_tvalid", stream_tvalid, 1);
      chk("t2_tdata", stream_tdata, 64'h00000000_7FFFFFFF);
      chk("t2_tstrb", stream_tstrb, 8'h0F);
      cyc();

      // contention alternates
      cd = 31'h10; md = 31'h20;
      ctrl_valid_i = 1; mesh_valid_i = 1;
      for (int k = 0; k < 4; k++) begin
         ctrl_data_i = cd; mesh_data_i = md;
         cyc();
         chk("t3_order", {cr_s, mr_s}, (k % 2 == 0) ? 2'b10 : 2'b01);
         if (cr_s) cd++;
         if (mr_s) md++;
         if (k == 1) chk("t3_beat0", stream_tdata, 64'h00000020_80000010);
         if (k == 3) chk("t3_beat1", stream_tdata, 64'h00000021_80000011);
      end
      ctrl_valid_i = 0; mesh_valid_i = 0;
      cyc();

      // backpressure
      stream_tready = 0;
      md = 31'h100; mesh_valid_i = 1;
      for (int k = 0; k < 4; k++) begin
         mesh_data_i = md;
         cyc();
         chk("t4_ready", mr_s, k < 3);
         if (mr_s) md++;
      end
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("t4_stall", mr_s, 0);
         chk("t4_hold", stream_tdata, 64'h00000101_00000100);
      end
      stream_tready = 1;
      cyc();
      chk("t4_release", mr_s, 1);
      chk("t4_beat2", stream_tdata, 64'h00000103_00000102);
      chk("t4_tvalid", stream_tvalid, 1);
      mesh_valid_i = 0;
      cyc();
      chk("t4_drained", stream_tvalid, 0);
      chk("t4_idle", idle_o, 1);

      // second message lands at terminal count
      ctrl_valid_i = 1; ctrl_data_i = 31'h55;
      cyc();
      ctrl_valid_i = 0;
      repeat (FC - 1) cyc();
      chk("t5_nov", stream_tvalid, 0);
      ctrl_valid_i = 1; ctrl_data_i = 31'h56;
      cyc();
      chk("t5_acc", cr_s, 1);
      chk("t5_tvalid", stream_tvalid, 1);
      chk("t5_tstrb", stream_tstrb, 8'hFF);
      chk("t5_tdata", stream_tdata, 64'h80000056_80000055);
      ctrl_valid_i = 0;
      cyc();
      chk("t5_nohalf", stream_tvalid, 0);
      chk("t5_idle", idle_o, 1);

      // reset with a pending beat and partial lane
      stream_tready = 0;
      ctrl_valid_i = 1; mesh_valid_i = 1;
      ctrl_data_i = 31'h1; mesh_data_i = 31'h2;
      cyc();
      ctrl_valid_i = 0;
      cyc();
      mesh_data_i = 31'h3;
      cyc();
      chk("t6_pre_tvalid", stream_tvalid, 1);
      chk("t6_pre_idle", idle_o, 0);
      mesh_valid_i = 0;
      rst_i = 1;
      cyc();
      chk("t6_tvalid", stream_tvalid, 0);
      chk("t6_idle", idle_o, 1);
      chk("t6_tdata", stream_tdata, 0);
      rst_i = 0; stream_tready = 1;
      seen = 0;
      repeat (20) begin
         cyc();
         if (stream_tvalid === 1'b1) seen++;
      end
      chk("t6_never", seen, 0);
      ctrl_valid_i = 1; mesh_valid_i = 1;
      cyc();
      chk("t6_prio", {cr_s, mr_s}, 2'b10);
      ctrl_valid_i = 0; mesh_valid_i = 0;

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if ((i / 50) % 3 == 2) begin
            ctrl_valid_i = 0; mesh_valid_i = 0;
         end else begin
            ctrl_valid_i = ($urandom % 3) != 0;
            mesh_valid_i = ($urandom % 3) != 0;
         end
         ctrl_data_i   = 31'($urandom);
         mesh_data_i   = 31'($urandom);
         stream_tready = ($urandom % 10) < 7;
         cyc();
      end
      ctrl_valid_i = 0; mesh_valid_i = 0; stream_tready = 1;
      repeat (FC + 8) cyc();
      chk("rnd_sb_empty", sbq.size(), 0);
      chk("rnd_idle", idle_o, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
